// File: rtl/cpu7_excp_ctl.sv
// Exception / ertn controller for the cpu7 _e stage: CSR access gating, trap
// priority, and an IFU redirect handshake. Optional macro: CPU7_EXT_INTR_SYNC_EN.
module cpu7_excp_ctl #(
    parameter int GRLEN          = 32,
    parameter int LSOC1K_CSR_BIT = 14
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      valid_e,
    input  logic [GRLEN-1:0]          pc_e,
    input  logic [1:0]                csr_op_e,
    input  logic [LSOC1K_CSR_BIT-1:0] csr_num_e,
    input  logic [GRLEN-1:0]          rd_data_e,
    input  logic [GRLEN-1:0]          rj_data_e,
    input  logic                      ertn_e,
    input  logic                      syscall_e,
    input  logic                      break_e,
    input  logic                      ine_e,
    input  logic                      ale_e,
    input  logic [GRLEN-1:0]          mem_addr_e,
    input  logic                      csr_crmd_ie,
    input  logic                      csr_timer_intr,
    input  logic                      ext_intr,
    input  logic [GRLEN-1:0]          csr_eentry,
    input  logic [GRLEN-1:0]          csr_era,
    input  logic                      ifu_redirect_ack,
    output logic [LSOC1K_CSR_BIT-1:0] csr_raddr,
    output logic [LSOC1K_CSR_BIT-1:0] csr_waddr,
    output logic [GRLEN-1:0]          csr_wdata,
    output logic [GRLEN-1:0]          csr_mask,
    output logic                      csr_wen,
    output logic                      exu_ifu_except,
    output logic [5:0]                ecl_csr_exccode_e,
    output logic [GRLEN-1:0]          ecl_csr_badv_e,
    output logic                      ecl_csr_ertn_e,
    output logic                      redirect_valid,
    output logic [GRLEN-1:0]          redirect_pc,
    output logic                      kill_e
);

    // state    | meaning
    // IDLE     | accepting _e events, CSR writes and traps allowed
    // WAIT_ACK | redirect outstanding, all _e events squashed until IFU ack
    typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

    state_t state;
    logic   ext_intr_q;
    logic   int_pend;
    logic   in_idle;
    logic   trap_take;
    logic   ertn_take;
    logic   is_csr_wr;

`ifdef CPU7_EXT_INTR_SYNC_EN
    logic ext_sync1;
    logic ext_sync2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext_sync1 <= 1'b0;
            ext_sync2 <= 1'b0;
        end else begin
            ext_sync1 <= ext_intr;
            ext_sync2 <= ext_sync1;
        end
    end

    assign ext_intr_q = ext_sync2;
`else
    assign ext_intr_q = ext_intr;
`endif

    assign int_pend  = csr_crmd_ie & (csr_timer_intr | ext_intr_q);
    assign in_idle   = (state == IDLE);
    assign trap_take = valid_e & in_idle &
                       (int_pend | ine_e | syscall_e | break_e | ale_e);
    assign ertn_take = valid_e & in_idle & ertn_e & ~trap_take;
    assign is_csr_wr = (csr_op_e == 2'd2) | (csr_op_e == 2'd3);

    assign csr_raddr = csr_num_e;
    assign csr_waddr = csr_num_e;
    assign csr_wdata = rd_data_e;
    assign csr_wen   = valid_e & is_csr_wr & in_idle & ~trap_take;

    always_comb begin
        csr_mask = '0;
        case (csr_op_e)
            2'd2:    csr_mask = '1;
            2'd3:    csr_mask = rj_data_e;
            default: csr_mask = '0;
        endcase
    end

    // Priority: interrupt > ine > syscall > break > ale
    always_comb begin
        ecl_csr_exccode_e = 6'h00;
        ecl_csr_badv_e    = '0;
        if (trap_take) begin
            ecl_csr_badv_e = pc_e;
            if (int_pend)
                ecl_csr_exccode_e = 6'h00;
            else if (ine_e)
                ecl_csr_exccode_e = 6'h0D;
            else if (syscall_e)
                ecl_csr_exccode_e = 6'h0B;
            else if (break_e)
                ecl_csr_exccode_e = 6'h0C;
            else begin
                ecl_csr_exccode_e = 6'h09;
                ecl_csr_badv_e    = mem_addr_e;
            end
        end
    end

    assign exu_ifu_except = trap_take;
    assign ecl_csr_ertn_e = ertn_take;
    assign kill_e         = trap_take | ertn_take | (state == WAIT_ACK);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_take) begin
                        state          <= WAIT_ACK;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= csr_eentry;
                    end else if (ertn_take) begin
                        state          <= WAIT_ACK;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= csr_era;
                    end
                end
                WAIT_ACK: begin
                    if (ifu_redirect_ack) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu7_excp_ctl.sv
// Scoreboard bench for cpu7_excp_ctl: directed vectors push expected outputs,
// a negedge monitor pops and compares. Follows CPU7_EXT_INTR_SYNC_EN if defined.
module tb_cpu7_excp_ctl;

    logic        clk;
    logic        resetn;
    logic        valid_e;
    logic [31:0] pc_e;
    logic [1:0]  csr_op_e;
    logic [13:0] csr_num_e;
    logic [31:0] rd_data_e;
    logic [31:0] rj_data_e;
    logic        ertn_e, syscall_e, break_e, ine_e, ale_e;
    logic [31:0] mem_addr_e;
    logic        csr_crmd_ie, csr_timer_intr, ext_intr;
    logic [31:0] csr_eentry, csr_era;
    logic        ifu_redirect_ack;
    logic [13:0] csr_raddr, csr_waddr;
    logic [31:0] csr_wdata, csr_mask;
    logic        csr_wen, exu_ifu_except;
    logic [5:0]  ecl_csr_exccode_e;
    logic [31:0] ecl_csr_badv_e;
    logic        ecl_csr_ertn_e, redirect_valid, kill_e;
    logic [31:0] redirect_pc;

    cpu7_excp_ctl dut (
        .clk(clk), .resetn(resetn), .valid_e(valid_e), .pc_e(pc_e),
        .csr_op_e(csr_op_e), .csr_num_e(csr_num_e), .rd_data_e(rd_data_e),
        .rj_data_e(rj_data_e), .ertn_e(ertn_e), .syscall_e(syscall_e),
        .break_e(break_e), .ine_e(ine_e), .ale_e(ale_e), .mem_addr_e(mem_addr_e),
        .csr_crmd_ie(csr_crmd_ie), .csr_timer_intr(csr_timer_intr),
        .ext_intr(ext_intr), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .ifu_redirect_ack(ifu_redirect_ack), .csr_raddr(csr_raddr),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_mask(csr_mask),
        .csr_wen(csr_wen), .exu_ifu_except(exu_ifu_except),
        .ecl_csr_exccode_e(ecl_csr_exccode_e), .ecl_csr_badv_e(ecl_csr_badv_e),
        .ecl_csr_ertn_e(ecl_csr_ertn_e), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .kill_e(kill_e)
    );

    typedef struct {
        string       name;
        logic [13:0] num;
        logic        wen;
        logic [31:0] mask;
        logic [31:0] wdata;
        logic        exc;
        logic [5:0]  code;
        logic [31:0] badv;
        logic        ertn;
        logic        kill;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cur_rpc  = 32'h0;
    exp_t        e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string vec, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", vec, field, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk(x.name, "csr_raddr", 32'(csr_raddr), 32'(x.num));
            chk(x.name, "csr_waddr", 32'(csr_waddr), 32'(x.num));
            chk(x.name, "csr_wen", 32'(csr_wen), 32'(x.wen));
            chk(x.name, "csr_mask", csr_mask, x.mask);
            chk(x.name, "csr_wdata", csr_wdata, x.wdata);
            chk(x.name, "except", 32'(exu_ifu_except), 32'(x.exc));
            if (x.exc) begin
                chk(x.name, "exccode", 32'(ecl_csr_exccode_e), 32'(x.code));
                chk(x.name, "badv", ecl_csr_badv_e, x.badv);
            end
            chk(x.name, "ertn", 32'(ecl_csr_ertn_e), 32'(x.ertn));
            chk(x.name, "kill_e", 32'(kill_e), 32'(x.kill));
            chk(x.name, "redirect_valid", 32'(redirect_valid), 32'(x.rv));
            chk(x.name, "redirect_pc", redirect_pc, x.rpc);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_e = 0; pc_e = 0; csr_op_e = 0; csr_num_e = 0;
        rd_data_e = 0; rj_data_e = 0; ertn_e = 0; syscall_e = 0;
        break_e = 0; ine_e = 0; ale_e = 0; mem_addr_e = 0;
        csr_crmd_ie = 0; csr_timer_intr = 0; ext_intr = 0;
        ifu_redirect_ack = 0;
    endtask

    function automatic exp_t base(input string name);
        exp_t x;
        x.name = name; x.num = 0; x.wen = 0; x.mask = 0; x.wdata = 0;
        x.exc = 0; x.code = 0; x.badv = 0; x.ertn = 0; x.kill = 0;
        x.rv = 0; x.rpc = cur_rpc;
        return x;
    endfunction

    // One cycle of the outstanding redirect, optionally acked in that cycle.
    task automatic wait_cycle(input string name, input logic ack);
        next_cycle(); idle_inputs(); ifu_redirect_ack = ack;
        e = base(name); e.kill = 1; e.rv = 1; sb.push_back(e);
    endtask

    initial begin
        idle_inputs();
        resetn = 0; csr_eentry = 32'h1C008000; csr_era = 32'h1C000104;

        next_cycle();
        e = base("reset"); sb.push_back(e);
        next_cycle(); resetn = 1;
        e = base("post_reset"); sb.push_back(e);

        next_cycle(); idle_inputs();
        valid_e = 1; csr_op_e = 3; csr_num_e = 0; rd_data_e = 4; rj_data_e = 4;
        e = base("csrxchg"); e.wen = 1; e.mask = 4; e.wdata = 4; sb.push_back(e);

        next_cycle(); idle_inputs();
        valid_e = 1; csr_op_e = 2; csr_num_e = 5; rd_data_e = 32'hDEAD;
        e = base("csrwr"); e.num = 5; e.wen = 1; e.mask = 32'hFFFFFFFF;
        e.wdata = 32'hDEAD; sb.push_back(e);

        next_cycle(); idle_inputs();
        valid_e = 1; csr_op_e = 1; csr_num_e = 7;
        e = base("csrrd"); e.num = 7; sb.push_back(e);

        next_cycle(); idle_inputs();
        csr_op_e = 2; rd_data_e = 32'h55;
        e = base("csrwr_invalid"); e.mask = 32'hFFFFFFFF; e.wdata = 32'h55;
        sb.push_back(e);

        next_cycle(); idle_inputs();
        valid_e = 1; syscall_e = 1; pc_e = 32'h1C000100;
        e = base("syscall"); e.exc = 1; e.code = 6'h0B; e.badv = 32'h1C000100;
        e.kill = 1; sb.push_back(e);
        cur_rpc = 32'h1C008000;

        wait_cycle("syscall_wait1", 0);
        next_cycle(); idle_inputs(); csr_eentry = 32'h1C00F000;
        valid_e = 1; csr_op_e = 2; syscall_e = 1; rd_data_e = 32'h77;
        e = base("waitack_squash"); e.mask = 32'hFFFFFFFF; e.wdata = 32'h77;
        e.kill = 1; e.rv = 1; sb.push_back(e);
        wait_cycle("syscall_wait3", 1);
        csr_eentry = 32'h1C008000;
        next_cycle(); idle_inputs();
        e = base("after_ack"); sb.push_back(e);

        next_cycle(); idle_inputs(); ifu_redirect_ack = 1;
        e = base("ack_in_idle"); sb.push_back(e);

        next_cycle(); idle_inputs();
        valid_e = 1; csr_crmd_ie = 1; csr_timer_intr = 1; ine_e = 1;
        csr_op_e = 2; pc_e = 32'h1C000180;
        e = base("int_priority"); e.mask = 32'hFFFFFFFF; e.exc = 1;
        e.code = 6'h00; e.badv = 32'h1C000180; e.kill = 1; sb.push_back(e);
        wait_cycle("int_wait", 1);

        next_cycle(); idle_inputs(); csr_eentry = 32'h1C009000;
        valid_e = 1; ale_e = 1; mem_addr_e = 32'h00000103; pc_e = 32'h1C000200;
        e = base("ale"); e.exc = 1; e.code = 6'h09; e.badv = 32'h00000103;
        e.kill = 1; sb.push_back(e);
        cur_rpc = 32'h1C009000;
        wait_cycle("ale_wait", 1);

        next_cycle(); idle_inputs();
        valid_e = 1; ine_e = 1; syscall_e = 1; break_e = 1; pc_e = 32'h1C000300;
        e = base("ine_prio"); e.exc = 1; e.code = 6'h0D; e.badv = 32'h1C000300;
        e.kill = 1; sb.push_back(e);
        wait_cycle("ine_wait", 1);

        next_cycle(); idle_inputs();
        valid_e = 1; break_e = 1; ale_e = 1; mem_addr_e = 32'h9; pc_e = 32'h1C000304;
        e = base("break_prio"); e.exc = 1; e.code = 6'h0C; e.badv = 32'h1C000304;
        e.kill = 1; sb.push_back(e);
        wait_cycle("break_wait", 1);

        next_cycle(); idle_inputs();
        valid_e = 1; ertn_e = 1;
        e = base("ertn"); e.ertn = 1; e.kill = 1; sb.push_back(e);
        cur_rpc = 32'h1C000104;
        wait_cycle("ertn_wait", 1);

        next_cycle(); idle_inputs(); csr_eentry = 32'h1C00A000;
        valid_e = 1; ertn_e = 1; syscall_e = 1; pc_e = 32'h1C000400;
        e = base("ertn_vs_trap"); e.exc = 1; e.code = 6'h0B;
        e.badv = 32'h1C000400; e.kill = 1; sb.push_back(e);
        cur_rpc = 32'h1C00A000;
        wait_cycle("ertn_vs_trap_wait", 1);

        next_cycle(); idle_inputs();
        valid_e = 1; csr_timer_intr = 1; ext_intr = 0; csr_op_e = 2; rd_data_e = 1;
        e = base("ie_off"); e.wen = 1; e.mask = 32'hFFFFFFFF; e.wdata = 1;
        sb.push_back(e);

        next_cycle(); idle_inputs(); csr_eentry = 32'h1C00B000;
        valid_e = 1; csr_crmd_ie = 1; ext_intr = 1; csr_op_e = 1; pc_e = 32'h1C000500;
`ifdef CPU7_EXT_INTR_SYNC_EN
        e = base("ext_sync_c0"); sb.push_back(e);
        next_cycle();
        e = base("ext_sync_c1"); sb.push_back(e);
        next_cycle();
`endif
        e = base("ext_trap"); e.exc = 1; e.code = 6'h00; e.badv = 32'h1C000500;
        e.kill = 1; sb.push_back(e);
        cur_rpc = 32'h1C00B000;
        wait_cycle("ext_wait", 0);

        next_cycle(); idle_inputs(); resetn = 0;
        cur_rpc = 32'h0;
        e = base("reset_in_wait"); sb.push_back(e);
        next_cycle(); resetn = 1;
        e = base("after_reset2"); sb.push_back(e);

        for (int i = 0; i < 20 && sb.size() > 0; i++) next_cycle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
